// File: rtl/vending_machine_multi_if.sv
// Front-panel / dispenser bundle for vending_machine_multi.
// With ITEM_STOCK_EN defined, the bundle also carries the sold_out flags.
interface vending_machine_multi_if #(
  parameter int unsigned N_ITEMS  = 4,
  parameter int unsigned ITEM_W   = 2,
  parameter int unsigned CREDIT_W = 5
);
  logic [ITEM_W-1:0]   item;
  logic                sel;
  logic                cancel;
  logic                dollar_10;
  logic                dollar_50;
  logic [CREDIT_W-1:0] amount_to_pay;
  logic [N_ITEMS-1:0]  item_rels;
  logic                change_return;
  logic                coin_reject;
  logic                busy;
`ifdef ITEM_STOCK_EN
  logic [N_ITEMS-1:0]  sold_out;

  modport master (
    output item, sel, cancel, dollar_10, dollar_50,
    input  amount_to_pay, item_rels, change_return, coin_reject, busy, sold_out
  );
  modport slave (
    input  item, sel, cancel, dollar_10, dollar_50,
    output amount_to_pay, item_rels, change_return, coin_reject, busy, sold_out
  );
`else
  modport master (
    output item, sel, cancel, dollar_10, dollar_50,
    input  amount_to_pay, item_rels, change_return, coin_reject, busy
  );
  modport slave (
    input  item, sel, cancel, dollar_10, dollar_50,
    output amount_to_pay, item_rels, change_return, coin_reject, busy
  );
`endif
endinterface

// File: rtl/vending_machine_multi.sv
// Multi-product vending controller: $10/$50 coins, cancel/refund, one $10 of change per clock.
// Optional per-item stock counters and sold_out flags are enabled by defining ITEM_STOCK_EN.
module vending_machine_multi #(
  parameter int unsigned                N_ITEMS  = 4,
  parameter int unsigned                ITEM_W   = 2,
  parameter int unsigned                PRICE_W  = 4,
  parameter logic [N_ITEMS*PRICE_W-1:0] PRICES   = {4'd6, 4'd5, 4'd3, 4'd2},
  parameter int unsigned                CREDIT_W = 5
`ifdef ITEM_STOCK_EN
  , parameter logic [3:0]               STOCK_INIT = 4'd4
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  vending_machine_multi_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, COLLECT, RELEASE, CHANGE} state_t;

  localparam logic [ITEM_W:0] ITEM_LIMIT = (ITEM_W+1)'(N_ITEMS);

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [ITEM_W-1:0]   item_q, item_d;
  logic [CREDIT_W-1:0] amount_q, amount_d;
  logic                reject_q, reject_d;
  logic                d10_dly1, d10_dly2, d50_dly1, d50_dly2;

  logic                p10, p50;
  logic [CREDIT_W-1:0] coin_inc, credit_sum;
  logic [PRICE_W-1:0]  price_sel, price_cur;
  logic [CREDIT_W-1:0] price_sel_w, price_cur_w;
  logic                item_ok;
  logic [N_ITEMS-1:0]  item_rels_c;
  logic                change_c;

`ifdef ITEM_STOCK_EN
  logic [3:0]          stock_q [N_ITEMS];
  logic [3:0]          stock_d [N_ITEMS];
  logic [N_ITEMS-1:0]  sold_c;

  always_comb begin
    sold_c = '0;
    for (int unsigned i = 0; i < N_ITEMS; i++) sold_c[i] = (stock_q[i] == 4'd0);
  end
  assign bus.sold_out = sold_c;
`endif

  assign p10         = d10_dly1 & ~d10_dly2;
  assign p50         = d50_dly1 & ~d50_dly2;
  assign coin_inc    = (p10 ? CREDIT_W'(1) : '0) + (p50 ? CREDIT_W'(5) : '0);
  assign credit_sum  = credit_q + coin_inc;
  assign price_sel   = PRICES[int'(bus.item)*PRICE_W +: PRICE_W];
  assign price_cur   = PRICES[int'(item_q)*PRICE_W +: PRICE_W];
  assign price_sel_w = CREDIT_W'(price_sel);
  assign price_cur_w = CREDIT_W'(price_cur);

  always_comb begin
    item_ok = ({1'b0, bus.item} < ITEM_LIMIT);
`ifdef ITEM_STOCK_EN
    item_ok = item_ok && !sold_c[bus.item];
`endif
  end

  always_comb begin
    state_d     = state_q;
    credit_d    = credit_q;
    item_d      = item_q;
    amount_d    = amount_q;
    reject_d    = (p10 | p50) && (state_q != COLLECT);
    item_rels_c = '0;
    change_c    = 1'b0;
`ifdef ITEM_STOCK_EN
    stock_d     = stock_q;
`endif
    case (state_q)
      IDLE: begin
        amount_d = '0;
        credit_d = '0;
        if (bus.sel && item_ok) begin
          item_d   = bus.item;
          amount_d = price_sel_w;
          state_d  = COLLECT;
        end
      end
      COLLECT: begin
        credit_d = credit_sum;
        // Cancel wins over reaching the price: the buyer asked for a refund.
        if (bus.cancel) begin
          amount_d = '0;
          state_d  = (credit_sum == '0) ? IDLE : CHANGE;
        end else if (credit_sum >= price_cur_w) begin
          amount_d = '0;
          state_d  = RELEASE;
        end else begin
          amount_d = price_cur_w - credit_sum;
        end
      end
      RELEASE: begin
        item_rels_c = N_ITEMS'(1) << item_q;
        amount_d    = '0;
        credit_d    = credit_q - price_cur_w;
        state_d     = (credit_q > price_cur_w) ? CHANGE : IDLE;
`ifdef ITEM_STOCK_EN
        if (stock_q[item_q] != 4'd0) stock_d[item_q] = stock_q[item_q] - 4'd1;
`endif
      end
      CHANGE: begin
        // credit_q doubles as the pending-change count here.
        change_c = (credit_q != '0);
        amount_d = '0;
        credit_d = (credit_q != '0) ? credit_q - CREDIT_W'(1) : '0;
        if (credit_q <= CREDIT_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      credit_q <= '0;
      item_q   <= '0;
      amount_q <= '0;
      reject_q <= 1'b0;
      d10_dly1 <= 1'b0;
      d10_dly2 <= 1'b0;
      d50_dly1 <= 1'b0;
      d50_dly2 <= 1'b0;
`ifdef ITEM_STOCK_EN
      for (int unsigned i = 0; i < N_ITEMS; i++) stock_q[i] <= STOCK_INIT;
`endif
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      item_q   <= item_d;
      amount_q <= amount_d;
      reject_q <= reject_d;
      d10_dly1 <= bus.dollar_10;
      d10_dly2 <= d10_dly1;
      d50_dly1 <= bus.dollar_50;
      d50_dly2 <= d50_dly1;
`ifdef ITEM_STOCK_EN
      stock_q  <= stock_d;
`endif
    end
  end

  assign bus.amount_to_pay = amount_q;
  assign bus.item_rels     = item_rels_c;
  assign bus.change_return = change_c;
  assign bus.coin_reject   = reject_q;
  assign bus.busy          = (state_q != IDLE);

endmodule

// File: tb/tb_vending_machine_multi.sv
// Directed bench for vending_machine_multi; inputs change and outputs are checked on negedge.
// With ITEM_STOCK_EN defined, the DUT is built with STOCK_INIT=1 and a sold-out check is added.
module tb_vending_machine_multi;
  logic clk = 1'b0;
  logic reset;
  int   n_total = 0;
  int   n_bad   = 0;

  always #5 clk = ~clk;

  vending_machine_multi_if #(.N_ITEMS(4), .ITEM_W(2), .CREDIT_W(5)) bus ();

`ifdef ITEM_STOCK_EN
  vending_machine_multi #(
    .N_ITEMS(4), .ITEM_W(2), .PRICE_W(4), .PRICES({4'd6, 4'd5, 4'd3, 4'd2}),
    .CREDIT_W(5), .STOCK_INIT(4'd1)
  ) dut (.clk(clk), .reset(reset), .bus(bus));
`else
  vending_machine_multi #(
    .N_ITEMS(4), .ITEM_W(2), .PRICE_W(4), .PRICES({4'd6, 4'd5, 4'd3, 4'd2}),
    .CREDIT_W(5)
  ) dut (.clk(clk), .reset(reset), .bus(bus));
`endif

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic press_sel(input logic [1:0] it);
    bus.item = it;
    bus.sel  = 1'b1;
    cyc();
    bus.sel  = 1'b0;
  endtask

  // One-cycle coin; on return its credit is already visible.
  task automatic coin(input logic c10, input logic c50);
    bus.dollar_10 = c10;
    bus.dollar_50 = c50;
    cyc();
    bus.dollar_10 = 1'b0;
    bus.dollar_50 = 1'b0;
    cyc();
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_amt"},  32'(bus.amount_to_pay), 32'd0);
    check_eq({tag, "_rels"}, 32'(bus.item_rels),     32'd0);
    check_eq({tag, "_chg"},  32'(bus.change_return), 32'd0);
    check_eq({tag, "_rej"},  32'(bus.coin_reject),   32'd0);
    check_eq({tag, "_busy"}, 32'(bus.busy),          32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.item = '0; bus.sel = 1'b0; bus.cancel = 1'b0;
    bus.dollar_10 = 1'b0; bus.dollar_50 = 1'b0;
    repeat (3) cyc();
    check_idle_outputs("reset");
    reset = 1'b0;
    cyc();

    // Item1 ($30) paid with three $10 coins.
    press_sel(2'd1);
    check_eq("t1_amt3", 32'(bus.amount_to_pay), 32'd3);
    check_eq("t1_busy", 32'(bus.busy), 32'd1);
    coin(1'b1, 1'b0);
    check_eq("t1_amt2", 32'(bus.amount_to_pay), 32'd2);
    coin(1'b1, 1'b0);
    check_eq("t1_amt1", 32'(bus.amount_to_pay), 32'd1);
    coin(1'b1, 1'b0);
    check_eq("t1_amt0", 32'(bus.amount_to_pay), 32'd0);
    check_eq("t1_rels", 32'(bus.item_rels), 32'b0010);
    check_eq("t1_chg",  32'(bus.change_return), 32'd0);
    cyc();
    check_eq("t1_rels_off", 32'(bus.item_rels), 32'd0);
    check_eq("t1_chg_off",  32'(bus.change_return), 32'd0);
    check_eq("t1_idle",     32'(bus.busy), 32'd0);

    // Item0 ($20) paid with $50: three $10 back.
    press_sel(2'd0);
    check_eq("t2_amt", 32'(bus.amount_to_pay), 32'd2);
    coin(1'b0, 1'b1);
    check_eq("t2_amt0", 32'(bus.amount_to_pay), 32'd0);
    check_eq("t2_rels", 32'(bus.item_rels), 32'b0001);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check_eq("t2_chg_on",  32'(bus.change_return), 32'd1);
      check_eq("t2_rels_off", 32'(bus.item_rels), 32'd0);
    end
    cyc();
    check_eq("t2_chg_end", 32'(bus.change_return), 32'd0);
    check_eq("t2_idle",    32'(bus.busy), 32'd0);

    // Item3 ($60) with both coins together: exact payment.
    press_sel(2'd3);
    check_eq("t3_amt", 32'(bus.amount_to_pay), 32'd6);
    coin(1'b1, 1'b1);
    check_eq("t3_amt0", 32'(bus.amount_to_pay), 32'd0);
    check_eq("t3_rels", 32'(bus.item_rels), 32'b1000);
    cyc();
    check_eq("t3_chg",  32'(bus.change_return), 32'd0);
    check_eq("t3_idle", 32'(bus.busy), 32'd0);

    // Item2 ($50), $20 in, sel ignored mid-collect, then cancel.
    press_sel(2'd2);
    check_eq("t4_amt5", 32'(bus.amount_to_pay), 32'd5);
    coin(1'b1, 1'b0);
    check_eq("t4_amt4", 32'(bus.amount_to_pay), 32'd4);
    press_sel(2'd3);
    check_eq("t4_sel_ign", 32'(bus.amount_to_pay), 32'd4);
    coin(1'b1, 1'b0);
    check_eq("t4_amt3", 32'(bus.amount_to_pay), 32'd3);
    bus.cancel = 1'b1;
    cyc();
    bus.cancel = 1'b0;
    check_eq("t4_chg1", 32'(bus.change_return), 32'd1);
    check_eq("t4_rels", 32'(bus.item_rels), 32'd0);
    check_eq("t4_amt0", 32'(bus.amount_to_pay), 32'd0);
    cyc();
    check_eq("t4_chg2", 32'(bus.change_return), 32'd1);
    check_eq("t4_rels2", 32'(bus.item_rels), 32'd0);
    cyc();
    check_eq("t4_chg_end", 32'(bus.change_return), 32'd0);
    check_eq("t4_idle",    32'(bus.busy), 32'd0);

    // Cancel with no credit goes straight back to IDLE.
    press_sel(2'd0);
    check_eq("t5_busy", 32'(bus.busy), 32'd1);
    bus.cancel = 1'b1;
    cyc();
    bus.cancel = 1'b0;
    check_eq("t5_idle", 32'(bus.busy), 32'd0);
    check_eq("t5_chg",  32'(bus.change_return), 32'd0);

    // Coin in IDLE is rejected once.
    coin(1'b1, 1'b0);
    check_eq("t6_rej", 32'(bus.coin_reject), 32'd1);
    check_eq("t6_busy", 32'(bus.busy), 32'd0);
    cyc();
    check_eq("t6_rej_off", 32'(bus.coin_reject), 32'd0);

    // Held coin counts once; then overpay and reset during change.
    press_sel(2'd2);
    check_eq("t7_amt5", 32'(bus.amount_to_pay), 32'd5);
    bus.dollar_10 = 1'b1;
    repeat (5) cyc();
    bus.dollar_10 = 1'b0;
    cyc();
    check_eq("t7_held", 32'(bus.amount_to_pay), 32'd4);
    check_eq("t7_rej",  32'(bus.coin_reject), 32'd0);
    coin(1'b1, 1'b0);
    check_eq("t7_amt3", 32'(bus.amount_to_pay), 32'd3);
    coin(1'b0, 1'b1);
    check_eq("t7_rels", 32'(bus.item_rels), 32'b0100);
    cyc();
    check_eq("t7_chg", 32'(bus.change_return), 32'd1);
    reset = 1'b1;
    cyc();
    check_idle_outputs("t7_rst");
    reset = 1'b0;
    cyc();
    check_eq("t7_chg_post", 32'(bus.change_return), 32'd0);
    cyc();
    check_eq("t7_chg_post2", 32'(bus.change_return), 32'd0);
    check_eq("t7_busy_post", 32'(bus.busy), 32'd0);

`ifdef ITEM_STOCK_EN
    check_eq("s_sold_init", 32'(bus.sold_out), 32'd0);
    press_sel(2'd0);
    coin(1'b0, 1'b1);
    check_eq("s_rels", 32'(bus.item_rels), 32'b0001);
    repeat (4) cyc();
    check_eq("s_idle", 32'(bus.busy), 32'd0);
    check_eq("s_sold", 32'(bus.sold_out), 32'b0001);
    press_sel(2'd0);
    check_eq("s_sel_ign_busy", 32'(bus.busy), 32'd0);
    check_eq("s_sel_ign_amt",  32'(bus.amount_to_pay), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
